memory_arbiter: RTL
===================

# memory_arbiter

Sequences a single-port unified instruction/data memory between the fetch stage and the memory stage of the pipelined RISC-V core. It grants one requester at a time, normally favouring data accesses because they belong to the older instruction. A bounded-starvation counter keeps data accesses from blocking fetch indefinitely. The block sits between the pipeline's fetch and memory-stage ports and the shared memory; the pipeline stalls on any pending request that has not yet seen its ready pulse.

## Interface
Parameters:
- FETCH_STARVE_MAX, 4: consecutive data grants allowed while a fetch waits; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level, held with if_addr stable until if_ready.
- if_addr  in  32  fetch address.
- if_kill  in  1  pipeline flush; cancels the pending or in-flight fetch.
- if_rdata  out  32  fetch data; valid only while if_ready=1.
- if_ready  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; level, held with the dm_* inputs stable until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid only while dm_ready=1.
- dm_ready  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request; held until mem_done.
- mem_we  out  1  write enable to memory.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_done  in  1  one-cycle completion from memory; mem_rdata is valid with it.
- mem_rdata  in  32  memory read data.

## Operation
- FSM states: ARB_IDLE, ARB_FETCH, ARB_DATA.
- ARB_IDLE: sample the requests.
  - Data only: go to ARB_DATA.
  - Fetch only, with if_kill=0: go to ARB_FETCH.
  - Both pending: go to ARB_DATA, unless starve_cnt == FETCH_STARVE_MAX, in which case go to ARB_FETCH.
- On entry to a grant state, register mem_req=1, mem_we, mem_addr and mem_wdata from the granted requester. These stay constant until mem_done.
- ARB_FETCH/ARB_DATA on mem_done: deassert mem_req at the next edge and return to ARB_IDLE.
  - if_ready and dm_ready are combinational: (mem_done && state matches) && !kill_flag for fetch.
  - rdata outputs pass mem_rdata through.
- starve_cnt (4 bits):
  - Increment on each data grant made while if_req=1 and if_kill=0.
  - Clear on any fetch grant, and whenever if_req=0 in ARB_IDLE.
  - Saturates at FETCH_STARVE_MAX.
- kill_flag:
  - Set when if_kill=1 in ARB_FETCH. The memory transaction completes normally, but if_ready is suppressed.
  - Cleared on return to ARB_IDLE.
  - if_kill=1 in ARB_IDLE blocks a fetch grant that cycle.
  - if_kill has no effect on data transactions.
- Stores: mem_we=1. dm_ready pulses on mem_done, and dm_rdata is don't-care.

## Timing
- Reset values: state=ARB_IDLE, starve_cnt=0, kill_flag=0, and all mem_* outputs 0. if_ready and dm_ready are 0, and if_rdata and dm_rdata are 0 by gating.
- Request sampled in ARB_IDLE at cycle t; mem_req=1 from t+1.
- Earliest mem_done is at t+1, giving if_ready/dm_ready at t+1. Minimum access is 2 cycles.
- When ready pulses at cycle d, the arbiter is in ARB_IDLE at d+1. A requester deasserting or changing its request at d+1 is therefore never re-granted stale.
- Back-to-back accesses from one requester: one idle cycle between memory transactions.
- Reset asserted mid-transaction: return to ARB_IDLE next edge, and drop mem_req regardless of mem_done. The memory shares the same reset and abandons the access.
- if_kill and mem_done in the same cycle in ARB_FETCH: if_ready is suppressed.
- Requests that arrive while a transaction is in flight wait; there is no queueing beyond the single grant.

## Structure
- Package memory_arbiter_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_FETCH, ARB_DATA}.
  - Width constants XLEN=32 and STARVE_W=4.
- No sub-module. The FSM, starve counter, kill flag and request register are inline in a single module.

## Test plan
- Single fetch: if_req=1, if_addr=0x0000_0010, mem_done 2 cycles after mem_req with mem_rdata=0x0051_0113 -> mem_addr=0x10, mem_we=0; if_ready pulses once with if_rdata=0x0051_0113.
- Simultaneous requests: if_req and dm_req asserted together, with dm_we=1, dm_addr=0x64, dm_wdata=0xDEAD_BEEF -> data granted first with mem_we=1 and mem_wdata=0xDEAD_BEEF; the fetch is granted after dm_ready.
- Starvation bound: FETCH_STARVE_MAX=4, dm_req held continuously with new addresses, if_req pending -> exactly 4 data grants, then a fetch grant, then the counter restarts from 0.
- Flush in flight: fetch granted, if_kill=1 one cycle later, mem_done 3 cycles later -> no if_ready pulse; FSM returns to ARB_IDLE; a pending dm_req is granted next.
- Reset mid-operation: reset asserted while mem_req=1 in ARB_DATA -> next edge mem_req=0, state ARB_IDLE, no dm_ready; a request after reset is serviced normally.
- Minimum latency: mem_done tied to mem_req -> ready 1 cycle after the request is sampled; alternating fetch/data requests each complete every 2 cycles.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and widths for the fetch/data memory arbiter.
package memory_arbiter_pkg;
  localparam int XLEN     = 32;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DATA
  } arb_state_t;
endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and the
// memory stage, favouring data with a bounded-starvation guard for fetch.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int FETCH_STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(FETCH_STARVE_MAX);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic                kill_flag;
  logic                fetch_ok;
  logic                starve_hit;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt >= STARVE_MAX) ? STARVE_MAX : cnt + 1'b1;
  endfunction

  assign fetch_ok   = if_req && !if_kill;
  assign starve_hit = (starve_cnt == STARVE_MAX);

  // A flush landing in the completion cycle must also suppress the pulse.
  assign if_ready = mem_done && (state == ARB_FETCH) && !kill_flag && !if_kill;
  assign dm_ready = mem_done && (state == ARB_DATA);
  assign if_rdata = if_ready ? mem_rdata : '0;
  assign dm_rdata = dm_ready ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      kill_flag  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          kill_flag <= 1'b0;
          if (dm_req && !(fetch_ok && starve_hit)) begin
            state     <= ARB_DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (fetch_ok)
              starve_cnt <= starve_inc(starve_cnt);
            else if (!if_req)
              starve_cnt <= '0;
          end else if (fetch_ok) begin
            state      <= ARB_FETCH;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end else if (!if_req) begin
            starve_cnt <= '0;
          end
        end
        ARB_FETCH: begin
          if (mem_done) begin
            state     <= ARB_IDLE;
            mem_req   <= 1'b0;
            kill_flag <= 1'b0;
          end else if (if_kill) begin
            kill_flag <= 1'b1;
          end
        end
        ARB_DATA: begin
          if (mem_done) begin
            state   <= ARB_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
